// File: rtl/i2c_target_responder.sv
// I2C target with a fixed 7-bit address. It oversamples SCL/SDA on clk_i, ACKs writes,
// and serves read bytes through a request/response interface to local logic.
module i2c_target_responder #(
  parameter int unsigned                I2C_ADDR_WIDTH = 7,
  parameter int unsigned                I2C_DATA_WIDTH = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0]  TARGET_ADDR    = 7'h22,
  parameter int unsigned                SYNC_STAGES    = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      sda_o,
  output logic [I2C_DATA_WIDTH-1:0] wr_data,
  output logic                      wr_valid,
  output logic                      rd_req,
  input  logic [I2C_DATA_WIDTH-1:0] rd_data,
  output logic                      rw_o,
  output logic                      busy,
  output logic                      start_det,
  output logic                      stop_det
);

  localparam int unsigned DW = I2C_DATA_WIDTH;
  localparam int unsigned AW = I2C_ADDR_WIDTH;
  localparam logic [3:0] ADDR_LAST = 4'(AW);
  localparam logic [3:0] DATA_LAST = 4'(DW - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_dly_q, sda_dly_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_cond, stop_cond;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [DW-1:0]   sh_q, sh_d;
  logic            sda_q, sda_d;
  logic            ack_drv_q, ack_drv_d;
  logic            ld_pend_q, ld_pend_d;
  logic            rw_q, rw_d;
  logic            busy_q, busy_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic            wr_valid_q, wr_valid_d;
  logic            rd_req_q, rd_req_d;
  logic            start_q, start_d;
  logic            stop_q, stop_d;

  // Synchronizers reset to the idle-bus level so reset release creates no false events.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_dly_q  <= scl_sync_q[SYNC_STAGES-1];
      sda_dly_q  <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_dly_q;
  assign scl_fall   = ~scl_s & scl_dly_q;
  // Requiring SCL high in both samples excludes an SCL edge in the same cycle.
  assign start_cond = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
  assign stop_cond  = scl_s & scl_dly_q & ~sda_dly_q & sda_s;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      sda_q      <= 1'b1;
      ack_drv_q  <= 1'b0;
      ld_pend_q  <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      wr_data_q  <= '0;
      wr_valid_q <= 1'b0;
      rd_req_q   <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      sda_q      <= sda_d;
      ack_drv_q  <= ack_drv_d;
      ld_pend_q  <= ld_pend_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      wr_data_q  <= wr_data_d;
      wr_valid_q <= wr_valid_d;
      rd_req_q   <= rd_req_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    sda_d      = sda_q;
    ack_drv_d  = ack_drv_q;
    ld_pend_d  = ld_pend_q;
    rw_d       = rw_q;
    busy_d     = busy_q;
    wr_data_d  = wr_data_q;
    wr_valid_d = 1'b0;
    rd_req_d   = 1'b0;
    start_d    = 1'b0;
    stop_d     = 1'b0;

    if (start_cond) begin
      state_d   = ADDR;
      cnt_d     = '0;
      sda_d     = 1'b1;
      ack_drv_d = 1'b0;
      ld_pend_d = 1'b0;
      start_d   = 1'b1;
    end else if (stop_cond) begin
      state_d   = IDLE;
      cnt_d     = '0;
      sda_d     = 1'b1;
      busy_d    = 1'b0;
      ack_drv_d = 1'b0;
      ld_pend_d = 1'b0;
      stop_d    = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: sda_d = 1'b1;
        ADDR: begin
          if (scl_rise) begin
            sh_d = {sh_q[DW-2:0], sda_s};
            if (cnt_q == ADDR_LAST) begin
              cnt_d = '0;
              if (sh_q[AW-1:0] == TARGET_ADDR) begin
                rw_d      = sda_s;
                busy_d    = 1'b1;
                rd_req_d  = sda_s;
                ack_drv_d = 1'b0;
                state_d   = ADDR_ACK;
              end else begin
                busy_d  = 1'b0;
                state_d = WAIT_STOP;
              end
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        ADDR_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (!ack_drv_q) begin
              sda_d     = 1'b0;
              ack_drv_d = 1'b1;
            end else begin
              ack_drv_d = 1'b0;
              cnt_d     = '0;
              if (rw_q) begin
                sh_d    = rd_data;
                sda_d   = rd_data[DW-1];
                state_d = RD_DATA;
              end else begin
                sda_d   = 1'b1;
                state_d = WR_DATA;
              end
            end
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            sh_d = {sh_q[DW-2:0], sda_s};
            if (cnt_q == DATA_LAST) begin
              cnt_d      = '0;
              wr_data_d  = {sh_q[DW-2:0], sda_s};
              wr_valid_d = 1'b1;
              ack_drv_d  = 1'b0;
              state_d    = WR_ACK;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        RD_DATA: begin
          // After a master ACK the next byte is fetched on the first fall, not on entry.
          if (scl_fall) begin
            if (ld_pend_q) begin
              ld_pend_d = 1'b0;
              cnt_d     = '0;
              sh_d      = rd_data;
              sda_d     = rd_data[DW-1];
            end else if (cnt_q == DATA_LAST) begin
              cnt_d   = '0;
              sda_d   = 1'b1;
              state_d = RD_ACK;
            end else begin
              cnt_d = cnt_q + 4'd1;
              sda_d = sh_q[DW-2];
              sh_d  = {sh_q[DW-2:0], sh_q[DW-1]};
            end
          end
        end
        RD_ACK: begin
          sda_d = 1'b1;
          if (scl_rise) begin
            if (!sda_s) begin
              rd_req_d  = 1'b1;
              ld_pend_d = 1'b1;
              state_d   = RD_DATA;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        WAIT_STOP: sda_d = 1'b1;
        default: begin
          state_d = IDLE;
          sda_d   = 1'b1;
        end
      endcase
    end
  end

  assign sda_o     = sda_q;
  assign wr_data   = wr_data_q;
  assign wr_valid  = wr_valid_q;
  assign rd_req    = rd_req_q;
  assign rw_o      = rw_q;
  assign busy      = busy_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;

endmodule

// File: tb/tb_i2c_target_responder.sv
// Directed and randomized bus-master bench for i2c_target_responder; checks transfers
// against a transaction-level expectation built from the target's address and byte lists.
module tb_i2c_target_responder;

  localparam int Q = 8;
  localparam logic [6:0] TADDR = 7'h22;

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl, m_sda;
  logic       sda_bus;
  logic       sda_o;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       rd_req;
  logic [7:0] rd_data = 8'h00;
  logic       rw_o, busy, start_det, stop_det;

  assign sda_bus = m_sda & sda_o;

  i2c_target_responder #(
    .I2C_ADDR_WIDTH(7),
    .I2C_DATA_WIDTH(8),
    .TARGET_ADDR(7'h22),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .scl_i(m_scl), .sda_i(sda_bus), .sda_o(sda_o),
    .wr_data(wr_data), .wr_valid(wr_valid), .rd_req(rd_req), .rd_data(rd_data),
    .rw_o(rw_o), .busy(busy), .start_det(start_det), .stop_det(stop_det)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] wr_got[$];
  logic [7:0] rd_q[$];
  int n_rdreq = 0, n_start = 0, n_stop = 0, n_low = 0;

  // Bus observer plus the local logic answering each read request from rd_q.
  always @(negedge clk) begin
    if (wr_valid) wr_got.push_back(wr_data);
    if (rd_req) begin
      n_rdreq++;
      if (rd_q.size() > 0) rd_data = rd_q.pop_front();
    end
    if (start_det) n_start++;
    if (stop_det)  n_stop++;
    if (!sda_o)    n_low++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_bit(input logic b, input logic same, output logic r);
    if (same) begin
      wq(Q);
      m_sda = b;
      m_scl = 1'b1;
    end else begin
      m_sda = b;
      wq(Q);
      m_scl = 1'b1;
    end
    wq(Q);
    r = sda_bus;
    wq(Q);
    m_scl = 1'b0;
    wq(Q);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wq(Q);
    m_scl = 1'b1; wq(Q);
    m_sda = 1'b0; wq(Q);
    m_scl = 1'b0; wq(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wq(Q);
    m_scl = 1'b1; wq(Q);
    m_sda = 1'b1; wq(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, input logic same, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], same, r);
    bus_bit(1'b1, same, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] v);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, 1'b0, r);
      v[i] = r;
    end
    bus_bit(nack, 1'b0, r);
  endtask

  logic       ack;
  logic [7:0] v;
  int         base, b0, s0, p0, l0, len;
  logic [6:0] ra;
  logic       rrw, match;
  logic [7:0] exp_bytes[$];
  bit         seen;

  initial begin
    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
    wq(3);
    check("reset_sda_o", {31'd0, sda_o}, 32'd1);
    check("reset_outs", {24'd0, wr_valid, rd_req, rw_o, busy, start_det, stop_det, 2'b00}, 32'd0);
    check("reset_wr_data", {24'd0, wr_data}, 32'd0);
    rst = 1'b0;
    wq(4);

    // Write 32 bytes 0..31
    base = wr_got.size(); s0 = n_start; p0 = n_stop;
    i2c_start();
    write_byte(8'h44, 1'b0, ack);
    check("t1_addr_ack", {31'd0, ack}, 32'd0);
    check("t1_rw_busy", {30'd0, rw_o, busy}, 32'b01);
    for (int i = 0; i < 32; i++) begin
      write_byte(8'(i), 1'b0, ack);
      check("t1_data_ack", {31'd0, ack}, 32'd0);
    end
    i2c_stop();
    wq(6);
    check("t1_wr_count", 32'(wr_got.size() - base), 32'd32);
    for (int i = 0; i < 32; i++) check("t1_wr_data", {24'd0, wr_got[base + i]}, 32'(i));
    check("t1_start_cnt", 32'(n_start - s0), 32'd1);
    check("t1_stop_cnt", 32'(n_stop - p0), 32'd1);
    check("t1_busy_after_stop", {31'd0, busy}, 32'd0);

    // Read 32 bytes 100..131
    b0 = n_rdreq;
    for (int i = 0; i < 32; i++) rd_q.push_back(8'(100 + i));
    i2c_start();
    write_byte(8'h45, 1'b0, ack);
    check("t2_addr_ack", {31'd0, ack}, 32'd0);
    check("t2_rw", {31'd0, rw_o}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      read_byte(i == 31, v);
      check("t2_rd_data", {24'd0, v}, 32'(100 + i));
    end
    wq(2 * Q);
    check("t2_rdreq_cnt", 32'(n_rdreq - b0), 32'd32);
    check("t2_sda_released", {31'd0, sda_o}, 32'd1);
    check("t2_busy_wait_stop", {31'd0, busy}, 32'd1);
    i2c_stop();
    wq(6);
    check("t2_busy_after_stop", {31'd0, busy}, 32'd0);

    // Write then repeated-START read
    base = wr_got.size(); s0 = n_start;
    i2c_start();
    write_byte(8'h44, 1'b0, ack);
    check("t3_wr_addr_ack", {31'd0, ack}, 32'd0);
    check("t3_rw0", {31'd0, rw_o}, 32'd0);
    write_byte(8'd64, 1'b0, ack);
    check("t3_wr_ack", {31'd0, ack}, 32'd0);
    rd_q.push_back(8'd63);
    i2c_start();
    write_byte(8'h45, 1'b0, ack);
    check("t3_rd_addr_ack", {31'd0, ack}, 32'd0);
    check("t3_rw1", {31'd0, rw_o}, 32'd1);
    read_byte(1'b1, v);
    check("t3_rd_data", {24'd0, v}, 32'd63);
    i2c_stop();
    wq(6);
    check("t3_start_cnt", 32'(n_start - s0), 32'd2);
    check("t3_wr_count", 32'(wr_got.size() - base), 32'd1);
    check("t3_wr_data", {24'd0, wr_got[base]}, 32'd64);

    // Non-matching address
    base = wr_got.size(); b0 = n_rdreq; l0 = n_low;
    i2c_start();
    write_byte(8'h46, 1'b0, ack);
    check("t4_addr_nack", {31'd0, ack}, 32'd1);
    write_byte(8'd5, 1'b0, ack);
    check("t4_data_nack", {31'd0, ack}, 32'd1);
    check("t4_busy", {31'd0, busy}, 32'd0);
    i2c_stop();
    wq(6);
    check("t4_sda_low_cycles", 32'(n_low - l0), 32'd0);
    check("t4_wr_count", 32'(wr_got.size() - base), 32'd0);
    check("t4_rdreq_cnt", 32'(n_rdreq - b0), 32'd0);

    // Reset while target drives a 0 data bit
    rd_q.push_back(8'h00);
    i2c_start();
    write_byte(8'h45, 1'b0, ack);
    check("t5_addr_ack", {31'd0, ack}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (sda_o == 1'b0) seen = 1'b1;
      else wq(1);
    end
    check("t5_target_drives_0", {31'd0, seen}, 32'd1);
    rst = 1'b1;
    #1;
    check("t5_rst_sda", {31'd0, sda_o}, 32'd1);
    check("t5_rst_outs", {24'd0, wr_valid, rd_req, rw_o, busy, start_det, stop_det, 2'b00}, 32'd0);
    check("t5_rst_wr_data", {24'd0, wr_data}, 32'd0);
    wq(3);
    rst = 1'b0;
    wq(3);
    write_byte(8'h44, 1'b0, ack);
    check("t5_no_start_ignored", {31'd0, ack}, 32'd1);
    base = wr_got.size();
    i2c_start();
    write_byte(8'h44, 1'b0, ack);
    check("t5_addr_ack_after", {31'd0, ack}, 32'd0);
    write_byte(8'h5A, 1'b0, ack);
    check("t5_data_ack", {31'd0, ack}, 32'd0);
    i2c_stop();
    wq(6);
    check("t5_wr_count", 32'(wr_got.size() - base), 32'd1);
    check("t5_wr_data", {24'd0, wr_got[base]}, 32'h5A);

    // SDA changing in the same cycle as SCL rise is data, not START/STOP
    i2c_start();
    base = wr_got.size(); s0 = n_start; p0 = n_stop;
    write_byte(8'h44, 1'b1, ack);
    check("t6_addr_ack", {31'd0, ack}, 32'd0);
    write_byte(8'hA5, 1'b1, ack);
    check("t6_data_ack", {31'd0, ack}, 32'd0);
    check("t6_no_start", 32'(n_start - s0), 32'd0);
    check("t6_no_stop", 32'(n_stop - p0), 32'd0);
    check("t6_wr_count", 32'(wr_got.size() - base), 32'd1);
    check("t6_wr_data", {24'd0, wr_got[base]}, 32'hA5);
    i2c_stop();
    wq(6);

    // Randomized transactions against a transaction-level expectation
    for (int t = 0; t < 6; t++) begin
      if ($urandom_range(1, 0) == 1) ra = TADDR;
      else begin
        ra = 7'($urandom_range(127, 0));
        if (ra == TADDR) ra = ra + 7'd1;
      end
      rrw   = 1'($urandom_range(1, 0));
      len   = $urandom_range(4, 1);
      match = (ra == TADDR);
      exp_bytes.delete();
      for (int i = 0; i < len; i++) exp_bytes.push_back(8'($urandom_range(255, 0)));
      base = wr_got.size(); b0 = n_rdreq;
      if (match && rrw) foreach (exp_bytes[i]) rd_q.push_back(exp_bytes[i]);
      i2c_start();
      write_byte({ra, rrw}, 1'b0, ack);
      check("rnd_addr_ack", {31'd0, ack}, {31'd0, !match});
      if (rrw && match) begin
        for (int i = 0; i < len; i++) begin
          read_byte(i == len - 1, v);
          check("rnd_rd_data", {24'd0, v}, {24'd0, exp_bytes[i]});
        end
      end else if (!rrw) begin
        for (int i = 0; i < len; i++) begin
          write_byte(exp_bytes[i], 1'b0, ack);
          check("rnd_data_ack", {31'd0, ack}, {31'd0, !match});
        end
      end
      i2c_stop();
      wq(6);
      check("rnd_wr_count", 32'(wr_got.size() - base), (match && !rrw) ? 32'(len) : 32'd0);
      if (match && !rrw)
        for (int i = 0; i < len; i++)
          check("rnd_wr_data", {24'd0, wr_got[base + i]}, {24'd0, exp_bytes[i]});
      check("rnd_rdreq_cnt", 32'(n_rdreq - b0), (match && rrw) ? 32'(len) : 32'd0);
      check("rnd_busy_idle", {31'd0, busy}, 32'd0);
      rd_q.delete();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_target_responder.md
Name: i2c_target_responder

Overview:
- Synthesizable I2C target (slave) device: the responder end of the I2C bus driven by the IICMB multi-bus controller.
- Oversamples scl/sda on the system clock, detects START/STOP, matches a fixed 7-bit address and ACKs writes.
- Hands received bytes to local logic through a valid-pulse interface and fetches read bytes through a request interface.
- Serves as on-chip loopback target and as a reference responder for controller regression.

Parameters:
I2C_ADDR_WIDTH, 7, target address width
I2C_DATA_WIDTH, 8, data byte width
TARGET_ADDR, 7'h22, address this target answers to
SYNC_STAGES, 2, synchronizer flops on scl_i/sda_i (min 2)

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous reset, active-high
scl_i  in  1  I2C clock from bus
sda_i  in  1  I2C data from bus
sda_o  out  1  open-drain data drive: 0 pulls low, 1 releases
wr_data  out  I2C_DATA_WIDTH  byte received from master
wr_valid  out  1  one-cycle pulse, wr_data valid
rd_req  out  1  one-cycle pulse, next read byte required
rd_data  in  I2C_DATA_WIDTH  byte to return to master
rw_o  out  1  R/W bit of current addressed transfer (1 = read)
busy  out  1  high from address match until STOP or a non-matching restart
start_det  out  1  one-cycle pulse on START or repeated START
stop_det  out  1  one-cycle pulse on STOP

Behaviour:
- Reset (async, active-high): sda_o=1, all other outputs 0, FSM=IDLE, shift and bit counters cleared; sda released the same cycle rst_i rises.
- Input path: SYNC_STAGES flops plus one delay flop for edge detect; pin-to-reaction latency = SYNC_STAGES+1 cycles. clk_i must be >= 16x the SCL frequency.
- Edge detect: scl_rise/scl_fall from synced scl.
- START: sda falls while synced scl is high in both current and previous sample.
- STOP: sda rises under the same scl-high condition.
- An scl edge in the same cycle as an sda change is treated as a bit edge, not START/STOP.
- START/STOP from any state overrides the FSM:
  - START -> ADDR, bit counter cleared, sda_o=1, start_det pulse.
  - STOP -> IDLE, sda_o=1, busy=0, stop_det pulse.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- ADDR: shift sda on each scl_rise, MSB first. On the 8th rise compare bits[7:1] with TARGET_ADDR.
  - Match: rw_o=bit0, busy=1, -> ADDR_ACK. If bit0=1, rd_req pulses in this same cycle.
  - Mismatch: -> WAIT_STOP, sda_o stays 1.
- ADDR_ACK / WR_ACK (drive ACK):
  - On the next scl_fall: sda_o=0.
  - On the following scl_fall: release sda_o=1 and enter WR_DATA (write transfer) or RD_DATA (read transfer).
  - For reads, that same fall loads rd_data into the shift register and drives its MSB onto sda_o instead of releasing.
- WR_DATA: shift on scl_rise. On the 8th rise: wr_data=byte, wr_valid pulse, -> WR_ACK. Every written byte is ACKed; there is no back-pressure.
- RD_DATA: shift out next bit on each scl_fall. After the 8th bit's scl_fall, release sda_o=1 -> RD_ACK.
- RD_ACK: sample sda on scl_rise.
  - 0 (ACK): rd_req pulse, -> RD_DATA; rd_data loaded on the next scl_fall.
  - 1 (NACK): -> WAIT_STOP.
- rd_data hold requirement: rd_data must be stable from the cycle after rd_req through the next scl_fall-detect cycle.
- WAIT_STOP: sda_o=1; ignore bits until START or STOP.
- Bit counter: 4-bit, cleared on START and on every ACK-phase exit; never wraps mid-byte.
- No clock stretching, no general call, no 10-bit addressing.
- Reset mid-transfer: bus released immediately. After reset the target ignores traffic until the next START.

Test Plan:
- START, 0x44, 32 bytes 0..31, STOP -> address ACKed; 32 wr_valid pulses with wr_data 0..31 in order; ACK driven low on each 9th clock; stop_det pulses once; busy falls at STOP.
- START, 0x45, read 32 bytes with master ACK (NACK on last); local logic answers each rd_req with 100+i -> master receives 100..131; exactly 32 rd_req pulses; sda released after final NACK; FSM in WAIT_STOP until STOP.
- START, 0x44 write 64, repeated START, 0x45 read 1 byte (rd_data=63) -> wr_valid with 64; two start_det pulses; rw_o goes 0 then 1; master reads 63.
- START, 0x46 (address 0x23), write 5 -> no ACK, sda_o stays 1 throughout; no wr_valid or rd_req; busy=0.
- Assert rst_i while target drives a 0 data bit during read -> sda_o=1 in the same cycle; all outputs 0. Then a new START with 0x44 -> normal ACK.
- sda toggles in the same sampled cycle as scl_rise -> no start_det or stop_det; the bit is shifted as data.
